ip_header_tx: RTL and testbench
===============================

# ip_header_tx

Transmit-side IPv4 header inserter.
- Accepts one header transaction on an `IP_INPUT_HEADER_IF.Input` port and the matching payload as an 8-bit AXI-Stream.
- Emits a single 8-bit AXI-Stream frame: a 20-byte IPv4 header followed by the payload.
- Sits directly downstream of the FPGA-side header producer and upstream of the Ethernet framer and MAC.

## Interface
Parameters:
- none; all widths are fixed by `IP_INPUT_HEADER_IF` and the 8-bit stream.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ip_hdr`  `IP_INPUT_HEADER_IF.Input`  —  header handshake and fields. `length` is the payload length in bytes.
- `s_axis_tdata`  in  8  payload byte.
- `s_axis_tvalid`  in  1  payload valid.
- `s_axis_tready`  out  1  payload ready.
- `s_axis_tlast`  in  1  last payload byte.
- `m_axis_tdata`  out  8  IP packet byte.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  last byte of the IP packet.

## Operation
States: `IDLE`, `SUM`, `HEADER`, `PAYLOAD`.

- **IDLE**
  - `hdr_ready` = 1.
  - On `hdr_valid && hdr_ready`: latch all fields and the current ID counter value, increment the ID counter, then go to `SUM`.
- **SUM** (one cycle)
  - Register the checksum. It is the one's-complement sum of the 10 header words with the checksum field taken as 0, end-around carry folded twice, then inverted.
  - Go to `HEADER`.
- **HEADER**
  - Byte counter 0..19 advances on each `m_axis_tvalid && m_axis_tready`.
  - Byte order, big-endian:
    - 0x45
    - {dscp, ecn}
    - total_length = (length + 20) mod 2^16
    - identification
    - 0x40, 0x00 (DF set, offset 0)
    - ttl
    - protocol
    - checksum
    - source_ip
    - dest_ip
  - After byte 19 is accepted: go to `PAYLOAD`, or to `IDLE` if `length == 0`. In the zero-length case byte 19 carries `m_axis_tlast` = 1.
- **PAYLOAD**
  - Combinational pass-through:
    - `m_axis_tdata` = `s_axis_tdata`
    - `m_axis_tvalid` = `s_axis_tvalid`
    - `s_axis_tready` = `m_axis_tready`
    - `m_axis_tlast` = `s_axis_tlast`
  - The accepted beat with `s_axis_tlast` = 1 returns the FSM to `IDLE`.
  - `length` is not checked against the beat count; `tlast` alone ends the frame.
- **Other states:** `s_axis_tready` = 0 everywhere except `PAYLOAD`.
- **ID counter:** 16 bits, 0 after reset, wraps 0xFFFF → 0x0000.
- **Stalls:** `m_axis_tdata` and `m_axis_tlast` hold stable while `m_axis_tvalid && !m_axis_tready`.

## Timing
Reset values (registered):
- state = `IDLE`, ID counter = 0, byte counter = 0.
- While `reset` is high: `hdr_ready`, `m_axis_tvalid`, `m_axis_tlast` and `s_axis_tready` are 0.
- `hdr_ready` = 1 from the first cycle after reset deasserts.

Latency:
- Header accepted in cycle N → `m_axis_tvalid` with byte 0 in cycle N+2.
- Without checksum generation (see Configuration) → cycle N+1.
- Header phase throughput: 1 byte/cycle when `m_axis_tready` = 1.
- Payload phase: zero added latency.

Boundary conditions:
- Reset mid-packet aborts immediately. The partial frame is not terminated with `tlast`; the downstream stage must tolerate this on reset.
- Next header: `hdr_ready` rises in the cycle after the final beat is accepted, giving at least one idle cycle between packets.
- A header presented while busy is held off (`hdr_ready` = 0); it is not dropped.

## Configuration
Macro `IP_HEADER_TX_CHECKSUM_EN`:
- Defined: the `SUM` state exists and the checksum is computed as above.
- Undefined: `SUM` is removed, `IDLE` goes directly to `HEADER`, and checksum bytes 10–11 are emitted as 0x0000 for downstream offload insertion.

## Structure
Package `ip_tx_pkg` holds:
- state enum `ip_tx_state_t`.
- `IP_VERSION_IHL` = 8'h45.
- `IP_FLAGS_FRAG` = 16'h4000.
- `IP_HDR_BYTES` = 20.

Sub-module `ip_checksum`:
- Combinational 10-word one's-complement sum, fold and invert.
- Reused later by the receive-side checker.

## Test plan
- **Basic frame.** Header src C0A8010A, dst C0A80101, ttl 64, protocol 0x11, length 8, dscp/ecn 0, first packet after reset; payload 8 bytes 0x00..0x07.
  - Bytes 2–3 = 0x001C, ID 0x0000, checksum 0xB775, then the payload.
  - `tlast` on 0x07; 28 beats total.
- **ID increment and wrap.** Send a second identical packet → ID 0x0001, checksum 0xB774. Preload to 65535 packets → ID 0xFFFF, then 0x0000.
- **Zero length.** length 0 → 20 beats, `tlast` on byte 19, total_length 0x0014, no `s_axis_tready` pulse.
- **Backpressure.** Random `m_axis_tready` (50%) on the basic frame → identical byte sequence; data stable during stalls; no payload byte lost or duplicated.
- **Reset mid-payload.** Assert `reset` after payload byte 3.
  - Next cycle: `m_axis_tvalid` = 0, `s_axis_tready` = 0.
  - After release: `hdr_ready` = 1 and the next packet carries ID 0x0000.
- **Checksum disabled.** With `IP_HEADER_TX_CHECKSUM_EN` undefined → checksum bytes 0x0000 and first-byte latency 1 cycle.

Source files
------------

// File: rtl/ip_tx_pkg.sv
// Shared types and constants for the IPv4 header transmit path.
package ip_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUM     = 2'd1,
        HEADER  = 2'd2,
        PAYLOAD = 2'd3
    } ip_tx_state_t;

    localparam logic [7:0]  IP_VERSION_IHL = 8'h45;   // version 4, IHL 5 words
    localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000; // DF set, fragment offset 0
    localparam int          IP_HDR_BYTES   = 20;

endpackage

// File: rtl/ip_header_tx_if.sv
// Header transaction bundle between the FPGA-side header producer and the
// IPv4 header inserter. Input is the consumer view, Output the producer view.
interface IP_INPUT_HEADER_IF;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;      // payload length in bytes
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;

    modport Input (
        input  hdr_valid, dscp, ecn, length, ttl, protocol, source_ip, dest_ip,
        output hdr_ready
    );

    modport Output (
        output hdr_valid, dscp, ecn, length, ttl, protocol, source_ip, dest_ip,
        input  hdr_ready
    );

    modport slave (
        input  hdr_valid, dscp, ecn, length, ttl, protocol, source_ip, dest_ip,
        output hdr_ready
    );

    modport master (
        output hdr_valid, dscp, ecn, length, ttl, protocol, source_ip, dest_ip,
        input  hdr_ready
    );
endinterface

// File: rtl/ip_checksum.sv
// Combinational IPv4 header checksum: one's-complement sum of the ten header
// words, end-around carry folded twice, then inverted. The caller supplies the
// checksum word as zero. Shared with the receive-side checker.
module ip_checksum
    import ip_tx_pkg::*;
(
    input  logic [IP_HDR_BYTES/2-1:0][15:0] i_words,
    output logic [15:0]                     o_csum
);

    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // Ten 16-bit words fit in 20 bits; two folds always absorb every carry.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < IP_HDR_BYTES/2; i++) begin
            w_sum = w_sum + {4'd0, i_words[i]};
        end
        w_fold1 = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
        w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};
        o_csum  = ~w_fold2;
    end

endmodule

// File: rtl/ip_header_tx.sv
// Transmit-side IPv4 header inserter: takes one header transaction plus an
// 8-bit payload stream and emits a 20-byte IPv4 header followed by the payload.
// Build option IP_HEADER_TX_CHECKSUM_EN: when defined the header checksum is
// computed in a one-cycle SUM state; otherwise bytes 10-11 go out as 0x0000
// for downstream offload and IDLE goes straight to HEADER.
module ip_header_tx
    import ip_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    IP_INPUT_HEADER_IF.Input ip_hdr,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

`ifdef IP_HEADER_TX_CHECKSUM_EN
    localparam ip_tx_state_t ST_AFTER_IDLE = SUM;
`else
    localparam ip_tx_state_t ST_AFTER_IDLE = HEADER;
`endif

    ip_tx_state_t r_state, w_next;

    logic [4:0]  r_cnt;       // header byte index 0..19
    logic [15:0] r_id;        // running identification counter
    logic [15:0] r_hid;       // identification of the packet in flight
    logic [5:0]  r_dscp;
    logic [1:0]  r_ecn;
    logic [15:0] r_len;
    logic [7:0]  r_ttl;
    logic [7:0]  r_proto;
    logic [31:0] r_src;
    logic [31:0] r_dst;

    logic        w_hdr_ready;
    logic        w_hdr_fire;
    logic        w_m_fire;
    logic [15:0] w_total_len;
    logic [15:0] w_csum;
    logic [15:0] w_csum_field;

    logic [IP_HDR_BYTES/2-1:0][15:0] w_base;  // header words, checksum word zero
    logic [IP_HDR_BYTES-1:0][7:0]    w_hdr;   // byte 0 sits at the top index

    assign ip_hdr.hdr_ready = w_hdr_ready;
    assign w_hdr_fire       = ip_hdr.hdr_valid && w_hdr_ready;
    assign w_m_fire         = m_axis_tvalid && m_axis_tready;
    assign w_total_len      = r_len + 16'(IP_HDR_BYTES);

    assign w_base = {IP_VERSION_IHL, r_dscp, r_ecn, w_total_len, r_hid,
                     IP_FLAGS_FRAG, r_ttl, r_proto, 16'h0000, r_src, r_dst};
    assign w_hdr  = {w_base[9:5], w_csum_field, w_base[3:0]};

    ip_checksum u_csum (
        .i_words (w_base),
        .o_csum  (w_csum)
    );

`ifdef IP_HEADER_TX_CHECKSUM_EN
    logic [15:0] r_csum;

    // Capture the checksum in SUM so header bytes are driven from flops.
    always_ff @(posedge clk) begin
        if (reset)                 r_csum <= '0;
        else if (r_state == SUM)   r_csum <= w_csum;
    end

    assign w_csum_field = r_csum;
`else
    // Checksum is inserted downstream; the adder output is intentionally dropped.
    logic w_unused_csum;
    assign w_unused_csum = ^w_csum;
    assign w_csum_field  = 16'h0000;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Header field capture, ID counter and header byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_hdr_fire) begin
                r_dscp  <= ip_hdr.dscp;
                r_ecn   <= ip_hdr.ecn;
                r_len   <= ip_hdr.length;
                r_ttl   <= ip_hdr.ttl;
                r_proto <= ip_hdr.protocol;
                r_src   <= ip_hdr.source_ip;
                r_dst   <= ip_hdr.dest_ip;
                r_hid   <= r_id;
                r_id    <= r_id + 16'd1;
            end
            if (r_state == HEADER && w_m_fire) begin
                r_cnt <= (r_cnt == 5'(IP_HDR_BYTES - 1)) ? 5'd0 : r_cnt + 5'd1;
            end
        end
    end

    // Next state and stream outputs; reset forces every handshake output low.
    always_comb begin
        w_next        = r_state;
        w_hdr_ready   = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = w_hdr[5'(IP_HDR_BYTES - 1) - r_cnt];
        case (r_state)
            IDLE: begin
                w_hdr_ready = 1'b1;
                if (ip_hdr.hdr_valid) w_next = ST_AFTER_IDLE;
            end
            SUM: begin
                w_next = HEADER;
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (r_cnt == 5'(IP_HDR_BYTES - 1)) && (r_len == 16'd0);
                if (m_axis_tready && r_cnt == 5'(IP_HDR_BYTES - 1)) begin
                    w_next = (r_len == 16'd0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (reset) begin
            w_hdr_ready   = 1'b0;
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ip_header_tx.sv
// Bench for ip_header_tx: a byte-level frame model built from the IPv4 rules
// is compared beat by beat, plus literal checks on known frames.
`timescale 1ns/1ps
module tb_ip_header_tx;

`ifdef IP_HEADER_TX_CHECKSUM_EN
    localparam bit          CSUM_EN = 1'b1;
    localparam int          EXP_LAT = 2;
    localparam logic [15:0] EXP_CS0 = 16'hB775;
    localparam logic [15:0] EXP_CS1 = 16'hB774;
`else
    localparam bit          CSUM_EN = 1'b0;
    localparam int          EXP_LAT = 1;
    localparam logic [15:0] EXP_CS0 = 16'h0000;
    localparam logic [15:0] EXP_CS1 = 16'h0000;
`endif

    typedef struct packed {
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] len;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
    } hdr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_axis_tdata, m_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;

    always #5 clk = ~clk;

    IP_INPUT_HEADER_IF ip_hdr_if ();

    ip_header_tx dut (
        .clk           (clk),
        .reset         (reset),
        .ip_hdr        (ip_hdr_if),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    hdr_t       hdr_q[$];
    logic [8:0] pay_q[$];   // {last, data}
    logic [8:0] exp_q[$];   // expected output beats {last, data}
    logic [15:0] m_id = 16'h0000;
    logic hdr_fire = 1'b0, pay_fire = 1'b0;
    bit   bp = 1'b0, src_rnd = 1'b0;
    logic [7:0] cap[0:63];
    int   cap_n = 0, last_idx = -1, st_cnt = 0, pay_acc = 0;
    int   hdr_cyc = 0, lat = -1;
    bit   lat_arm = 1'b0, last_prev = 1'b0, stall_prev = 1'b0;
    logic [7:0] stall_d;
    logic       stall_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference header words straight from the IPv4 field layout.
    function automatic void hdr_words(input hdr_t h, input logic [15:0] id, output logic [15:0] w[10]);
        w[0] = {8'h45, h.dscp, h.ecn};
        w[1] = h.len + 16'd20;
        w[2] = id;
        w[3] = 16'h4000;
        w[4] = {h.ttl, h.proto};
        w[5] = 16'h0000;
        w[6] = h.src[31:16];
        w[7] = h.src[15:0];
        w[8] = h.dst[31:16];
        w[9] = h.dst[15:0];
    endfunction

    function automatic logic [15:0] model_csum(input logic [15:0] w[10]);
        logic [31:0] s = 0;
        for (int i = 0; i < 10; i++) s = s + {16'd0, w[i]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic push_pkt(input hdr_t h, input logic [7:0] pl[$]);
        logic [15:0] w[10];
        hdr_words(h, m_id, w);
        w[5] = CSUM_EN ? model_csum(w) : 16'h0000;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({1'b0, w[i][15:8]});
            exp_q.push_back({(i == 9) && (pl.size() == 0), w[i][7:0]});
        end
        for (int i = 0; i < pl.size(); i++) begin
            exp_q.push_back({i == pl.size() - 1, pl[i]});
            pay_q.push_back({i == pl.size() - 1, pl[i]});
        end
        hdr_q.push_back(h);
        m_id = m_id + 16'd1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n >= 3000, 0);
        repeat (3) @(negedge clk);
    endtask

    // Input drivers: advance on accepted transfers, drive just after the edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (hdr_fire && hdr_q.size() > 0) void'(hdr_q.pop_front());
        if (hdr_q.size() > 0) begin
            ip_hdr_if.hdr_valid = 1'b1;
            ip_hdr_if.dscp      = hdr_q[0].dscp;
            ip_hdr_if.ecn       = hdr_q[0].ecn;
            ip_hdr_if.length    = hdr_q[0].len;
            ip_hdr_if.ttl       = hdr_q[0].ttl;
            ip_hdr_if.protocol  = hdr_q[0].proto;
            ip_hdr_if.source_ip = hdr_q[0].src;
            ip_hdr_if.dest_ip   = hdr_q[0].dst;
        end else begin
            ip_hdr_if.hdr_valid = 1'b0;
        end
        if (pay_fire && pay_q.size() > 0) void'(pay_q.pop_front());
        if (pay_q.size() > 0 && (!src_rnd || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid = 1'b1;
            {s_axis_tlast, s_axis_tdata} = pay_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
        m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor / compare process, sampling on the falling edge.
    initial forever begin
        logic [8:0] e;
        @(negedge clk);
        hdr_fire = !reset && ip_hdr_if.hdr_valid && ip_hdr_if.hdr_ready;
        pay_fire = !reset && s_axis_tvalid && s_axis_tready;
        if (reset) begin
            stall_prev = 0; last_prev = 0; lat_arm = 0;
        end else begin
            if (s_axis_tready) st_cnt++;
            if (pay_fire) pay_acc++;
            if (last_prev) begin
                chk("gap_hdr_ready", ip_hdr_if.hdr_ready, 1);
                chk("gap_tvalid", m_axis_tvalid, 0);
            end
            last_prev = 0;
            if (m_axis_tvalid) begin
                chk("busy_hdr_ready", ip_hdr_if.hdr_ready, 0);
                if (lat_arm) begin lat = cyc - hdr_cyc; lat_arm = 0; end
                if (!m_axis_tready) begin
                    if (stall_prev) begin
                        chk("stall_data", m_axis_tdata, stall_d);
                        chk("stall_last", m_axis_tlast, stall_l);
                    end
                    stall_prev = 1; stall_d = m_axis_tdata; stall_l = m_axis_tlast;
                end else begin
                    stall_prev = 0;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_axis_tdata, e[7:0]);
                        chk("beat_last", m_axis_tlast, e[8]);
                    end
                    if (cap_n < 64) cap[cap_n] = m_axis_tdata;
                    if (m_axis_tlast) begin last_prev = 1; last_idx = cap_n; end
                    cap_n++;
                end
            end else begin
                stall_prev = 0;
            end
            if (hdr_fire) begin hdr_cyc = cyc; lat_arm = 1; end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_t hb, hz, hx, hy;
        logic [7:0] pl[$];
        logic [15:0] w[10];
        int base;

        ip_hdr_if.hdr_valid = 0;
        s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = 0; m_axis_tready = 1;
        hb = '{dscp: 6'd0, ecn: 2'd0, len: 16'd8, ttl: 8'd64, proto: 8'h11,
               src: 32'hC0A8010A, dst: 32'hC0A80101};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hdr_ready", ip_hdr_if.hdr_ready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        @(posedge clk); #2 reset = 0;
        @(negedge clk);
        chk("post_rst_hdr_ready", ip_hdr_if.hdr_ready, 1);

        // Pin the checksum model against the known frame
        hdr_words(hb, 16'h0000, w);
        chk("model_csum_pin", model_csum(w), 16'hB775);

        // Basic frame
        pl = {}; for (int i = 0; i < 8; i++) pl.push_back(8'(i));
        cap_n = 0; lat = -1;
        push_pkt(hb, pl);
        wait_done("basic_done");
        chk("basic_beats", cap_n, 28);
        chk("basic_total_len", {cap[2], cap[3]}, 16'h001C);
        chk("basic_id", {cap[4], cap[5]}, 16'h0000);
        chk("basic_csum", {cap[10], cap[11]}, EXP_CS0);
        chk("basic_tlast_idx", last_idx, 27);
        chk("basic_last_byte", cap[27], 8'h07);
        chk("basic_latency", lat, EXP_LAT);

        // Second identical frame: ID increments
        cap_n = 0;
        push_pkt(hb, pl);
        wait_done("second_done");
        chk("second_id", {cap[4], cap[5]}, 16'h0001);
        chk("second_csum", {cap[10], cap[11]}, EXP_CS1);

        // Zero-length payload
        hz = hb; hz.len = 16'd0;
        pl = {};
        cap_n = 0; st_cnt = 0;
        push_pkt(hz, pl);
        wait_done("zero_done");
        chk("zero_beats", cap_n, 20);
        chk("zero_tlast_idx", last_idx, 19);
        chk("zero_total_len", {cap[2], cap[3]}, 16'h0014);
        chk("zero_s_tready_pulses", st_cnt, 0);

        // Backpressure on the basic frame
        pl = {}; for (int i = 0; i < 8; i++) pl.push_back(8'(i));
        bp = 1; cap_n = 0;
        push_pkt(hb, pl);
        wait_done("bp_done");
        bp = 0;
        chk("bp_beats", cap_n, 28);
        for (int i = 0; i < 8; i++) chk("bp_payload", cap[20 + i], 32'(i));

        // Different fields, bursty source, then back-to-back headers
        hx = '{dscp: 6'h2E, ecn: 2'b01, len: 16'd5, ttl: 8'd1, proto: 8'h06,
               src: 32'h0A000001, dst: 32'hFFFFFFFF};
        hy = hz; hy.src = 32'h01020304;
        pl = {}; for (int i = 0; i < 5; i++) pl.push_back(8'($urandom_range(0, 255)));
        bp = 1; src_rnd = 1;
        push_pkt(hx, pl);
        pl = {}; for (int i = 0; i < 3; i++) pl.push_back(8'(8'hA0 + i));
        hy.len = 16'd3;
        push_pkt(hy, pl);
        pl = {};
        hy.len = 16'd0;
        push_pkt(hy, pl);
        wait_done("mixed_done");
        bp = 0; src_rnd = 0;

        // ID wrap
        force dut.r_id = 16'hFFFF;
        #1 release dut.r_id;
        m_id = 16'hFFFF;
        pl = {}; for (int i = 0; i < 8; i++) pl.push_back(8'(i));
        cap_n = 0;
        push_pkt(hb, pl);
        wait_done("wrap1_done");
        chk("wrap_id_ffff", {cap[4], cap[5]}, 16'hFFFF);
        cap_n = 0;
        push_pkt(hb, pl);
        wait_done("wrap2_done");
        chk("wrap_id_0000", {cap[4], cap[5]}, 16'h0000);

        // Reset mid-payload after byte 3
        base = pay_acc;
        push_pkt(hb, pl);
        begin
            int n = 0;
            while (pay_acc < base + 4 && n < 200) begin @(negedge clk); n++; end
            chk("midrst_reach", n >= 200, 0);
        end
        @(posedge clk); #2 reset = 1;
        @(negedge clk);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_s_tready", s_axis_tready, 0);
        @(posedge clk); #2;
        exp_q.delete(); pay_q.delete(); hdr_q.delete();
        m_id = 16'h0000;
        @(posedge clk); #2 reset = 0;
        @(negedge clk);
        chk("midrst_hdr_ready", ip_hdr_if.hdr_ready, 1);
        cap_n = 0;
        push_pkt(hb, pl);
        wait_done("after_rst_done");
        chk("after_rst_id", {cap[4], cap[5]}, 16'h0000);
        chk("after_rst_csum", {cap[10], cap[11]}, EXP_CS0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
